// File: rtl/v_rams_pkg.sv
// Shared defaults and FSM state type for the v_rams burst reader.
package v_rams_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 6;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

endpackage

// File: rtl/v_rams_dp_dist.sv
// Distributed RAM with one synchronous write port and one asynchronous read port.
module v_rams_dp_dist #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] di,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= di;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/v_rams_reader.sv
// Burst read engine: streams cmd_len words from cmd_addr over a valid/ready port.
// The read-data port is do_data because "do" is a reserved word in SystemVerilog.
module v_rams_reader
    import v_rams_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] di,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    output logic              do_valid,
    input  logic              do_ready,
    output logic [DATA_W-1:0] do_data,
    output logic              do_last
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W:0]   remaining;
    logic [DATA_W-1:0] rdata;
    logic              cmd_accept;
    logic              load;
    logic              last_load;

    v_rams_dp_dist #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (we && !rst),
        .wa   (wa),
        .di   (di),
        .raddr(raddr),
        .rdata(rdata)
    );

    always_comb begin
        cmd_ready  = (state == IDLE);
        cmd_accept = cmd_valid && cmd_ready;
        load       = (state == BURST) && (!do_valid || do_ready);
        last_load  = load && (remaining == (ADDR_W+1)'(1));
        state_nxt  = state;
        case (state)
            IDLE:    if (cmd_accept) state_nxt = BURST;
            BURST:   if (last_load)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            raddr     <= '0;
            remaining <= '0;
            do_valid  <= 1'b0;
            do_last   <= 1'b0;
            do_data   <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_accept) begin
                raddr <= cmd_addr;
                // A zero length stands for a full 2**ADDR_W-word sweep.
                remaining <= (cmd_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, cmd_len};
            end
            if (load) begin
                do_data   <= rdata;
                do_last   <= (remaining == (ADDR_W+1)'(1));
                do_valid  <= 1'b1;
                raddr     <= raddr + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
            end else if (do_valid && do_ready) begin
                do_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_v_rams_reader.sv
// Self-checking bench for v_rams_reader: table bursts, corner sequences, random bursts.
module tb_v_rams_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [5:0]  wa;
    logic [15:0] di;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_addr;
    logic [5:0]  cmd_len;
    logic        do_valid;
    logic        do_ready;
    logic [15:0] do_data;
    logic        do_last;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [15:0] model [64];

    typedef struct {
        logic [5:0]  addr;
        logic [5:0]  len;
        logic [31:0] rdy_pat;
        logic [15:0] exp_first;
        int unsigned exp_words;
    } vec_t;

    vec_t vecs [4];

    v_rams_reader #(
        .DATA_W(16),
        .ADDR_W(6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wa       (wa),
        .di       (di),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .do_valid (do_valid),
        .do_ready (do_ready),
        .do_data  (do_data),
        .do_last  (do_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one command and consumes the whole burst under a do_ready pattern.
    task automatic run_burst(input logic [5:0] addr, input logic [5:0] len, input logic [31:0] pat,
                             output logic [15:0] first, output int unsigned words);
        int unsigned n;
        int unsigned cyc;
        int unsigned wait_cyc;
        logic        held;
        logic        rdy;
        logic [15:0] held_data;
        logic        held_last;
        n = (len == 0) ? 64 : int'(len);
        words = 0;
        first = '0;
        held = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        wait_cyc = 0;
        while (!cmd_ready && wait_cyc < 100) begin
            tick();
            wait_cyc++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
        chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("first_latency", {31'd0, do_valid}, 32'd1);
        cyc = 0;
        while (words < n && cyc < n + 60) begin
            if (held) begin
                chk("stall_data", {16'd0, do_data}, {16'd0, held_data});
                chk("stall_last", {31'd0, do_last}, {31'd0, held_last});
                chk("stall_valid", {31'd0, do_valid}, 32'd1);
            end
            rdy = (cyc < 32) ? pat[cyc] : 1'b1;
            do_ready = rdy;
            if (do_valid && rdy) begin
                chk("burst_data", {16'd0, do_data}, {16'd0, model[(int'(addr) + words) % 64]});
                chk("burst_last", {31'd0, do_last}, {31'd0, (words == n - 1)});
                if (words == 0) first = do_data;
                words++;
                held = 1'b0;
            end else if (do_valid) begin
                held = 1'b1;
                held_data = do_data;
                held_last = do_last;
            end else begin
                held = 1'b0;
            end
            tick();
            cyc++;
        end
        do_ready = 1'b1;
        chk("burst_drained", {31'd0, do_valid}, 32'd0);
        chk("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] first;
        int unsigned words;
        int unsigned got;
        int unsigned waited;

        rst = 1'b1; we = 1'b0; wa = '0; di = '0;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; do_ready = 1'b1;
        tick();
        tick();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_do_valid", {31'd0, do_valid}, 32'd0);
        chk("rst_do_last", {31'd0, do_last}, 32'd0);
        chk("rst_do_data", {16'd0, do_data}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 64; i++) begin
            we = 1'b1; wa = 6'(i); di = 16'hA000 + 16'(i);
            model[i] = 16'hA000 + 16'(i);
            tick();
        end
        we = 1'b0;

        vecs[0] = '{addr: 6'd5,  len: 6'd4, rdy_pat: 32'hFFFF_FFFF, exp_first: 16'hA005, exp_words: 4};
        vecs[1] = '{addr: 6'd62, len: 6'd4, rdy_pat: 32'hFFFF_FFFF, exp_first: 16'hA03E, exp_words: 4};
        vecs[2] = '{addr: 6'd0,  len: 6'd0, rdy_pat: 32'hFFFF_FFFF, exp_first: 16'hA000, exp_words: 64};
        vecs[3] = '{addr: 6'd10, len: 6'd3, rdy_pat: 32'hFFFF_FFF9, exp_first: 16'hA00A, exp_words: 3};
        for (int v = 0; v < 4; v++) begin
            run_burst(vecs[v].addr, vecs[v].len, vecs[v].rdy_pat, first, words);
            chk("vec_first", {16'd0, first}, {16'd0, vecs[v].exp_first});
            chk("vec_words", words, vecs[v].exp_words);
        end

        // Write to address 20 on the very edge that loads it: old data must come out.
        cmd_valid = 1'b1; cmd_addr = 6'd20; cmd_len = 6'd1; do_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        we = 1'b1; wa = 6'd20; di = 16'h1234;
        tick();
        we = 1'b0;
        chk("coll_valid", {31'd0, do_valid}, 32'd1);
        chk("coll_old_data", {16'd0, do_data}, 32'h0000_A014);
        chk("coll_last", {31'd0, do_last}, 32'd1);
        model[20] = 16'h1234;
        tick();
        run_burst(6'd20, 6'd1, 32'hFFFF_FFFF, first, words);
        chk("coll_new_data", {16'd0, first}, 32'h0000_1234);

        // Reset after the second word of a length-8 burst; a write during reset is dropped.
        cmd_valid = 1'b1; cmd_addr = 6'd0; cmd_len = 6'd8; do_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        got = 0;
        waited = 0;
        while (got < 2 && waited < 20) begin
            if (do_valid) got++;
            if (got < 2) begin
                tick();
                waited++;
            end
        end
        chk("rst_mid_seen2", got, 2);
        rst = 1'b1; we = 1'b1; wa = 6'd0; di = 16'hFFFF;
        tick();
        rst = 1'b0; we = 1'b0;
        chk("rst_mid_valid", {31'd0, do_valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rst_mid_quiet", {31'd0, do_valid}, 32'd0);
        end
        run_burst(6'd0, 6'd1, 32'hFFFF_FFFF, first, words);
        chk("rst_after_word", {16'd0, first}, 32'h0000_A000);
        chk("rst_after_count", words, 1);

        for (int r = 0; r < 25; r++) begin
            int unsigned nw;
            logic [5:0]  ra;
            logic [5:0]  rl;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < int'(nw); w++) begin
                we = 1'b1; wa = 6'($urandom_range(0, 63)); di = 16'($urandom);
                model[wa] = di;
                tick();
            end
            we = 1'b0;
            ra = 6'($urandom_range(0, 63));
            rl = (r % 8 == 7) ? 6'd0 : 6'($urandom_range(1, 12));
            run_burst(ra, rl, $urandom, first, words);
            chk("rand_words", words, (rl == 0) ? 64 : int'(rl));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
